logic_op_arbiter: RTL and testbench
===================================

Name: logic_op_arbiter

Overview:
- Shares one combinational logic unit (AND/OR/XOR/NOT) between NREQ requesters.
- Each requester issues a valid/ready operation request; the block arbitrates round-robin, captures the operands and computes the result.
- The result is returned on a single valid/ready response channel tagged with the requester index.
- Sits between the lab's stimulus sources (switch banks, test sequencers) and the gate datapath. The gate datapath is never driven directly by more than one source.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 8, operand/result width in bits.
- IDW, 2, requester index width; must equal ceil(log2(NREQ)).
- CNTW, 16, width of completed-operation counter.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester request valid.
- req_ready  output  NREQ  per-requester accept, one-hot or zero.
- req_op  input  2*NREQ  per-requester opcode; requester i in bits [2i+1:2i].
- req_a  input  WIDTH*NREQ  per-requester operand A; requester i in bits [WIDTH*i+WIDTH-1:WIDTH*i].
- req_b  input  WIDTH*NREQ  per-requester operand B, same packing as req_a.
- rsp_valid  output  1  response valid.
- rsp_ready  input  1  response consumer ready.
- rsp_id  output  IDW  index of the requester that owns rsp_data.
- rsp_data  output  WIDTH  operation result.
- busy  output  1  high whenever state is not IDLE.
- ops_done  output  CNTW  count of completed response handshakes; saturates at all-ones.

Behaviour:
- Clock/reset: one clock, clk; reset is asynchronous, active-low (rst_n).
- Reset values:
  - state=IDLE, req_ready=0, rsp_valid=0, rsp_id=0, rsp_data=0, busy=0, ops_done=0.
  - last_grant=NREQ-1, so requester 0 has priority first.
- Opcodes: 00 AND (A&B), 01 OR (A|B), 10 XOR (A^B), 11 NOT (~A, B ignored). All bitwise over WIDTH bits.
- IDLE state:
  - If any req_valid is high, the grant g is the first valid index searching upward from last_grant+1, wrapping modulo NREQ.
  - req_ready[g]=1 combinationally in that same cycle, and only for g. At the clock edge, op/A/B of g and id=g are captured and the state moves to EXEC.
  - If no req_valid is high, req_ready=0 and the state stays IDLE.
- EXEC state:
  - The captured operands pass through logic_unit; the result is registered into rsp_data and rsp_id is set to g. Next state is RESP.
  - req_ready=0.
- RESP state:
  - rsp_valid=1; rsp_data and rsp_id are held stable until rsp_valid&&rsp_ready.
  - On the handshake: rsp_valid drops next cycle, last_grant<=g, ops_done increments (saturating), and the state returns to IDLE.
  - req_ready=0 throughout RESP.
- Latency and throughput:
  - Request accepted in cycle 0; rsp_valid high in cycle 2 at the earliest.
  - Minimum 3 cycles per operation with rsp_ready held high.
- Fairness: a requester holding valid continuously is granted within NREQ operations.
- A requester may drop req_valid before being granted; no state changes.
- Requester inputs are ignored outside the IDLE state. Changes to op/A/B after acceptance do not affect the captured operation.
- A response handshake and a pending new request in the same cycle: the new request is arbitrated in the following IDLE cycle, using the updated last_grant.
- Reset asserted mid-operation: the in-flight operation is discarded, no response is emitted, and all registers return to their reset values immediately (asynchronously).
- ops_done at all-ones stays all-ones on further handshakes.
- The state encoding is a 2-bit register; the unused code 11 returns to IDLE on the next clock.

Decomposition:
- Shared package/include: opcode constants OP_AND=2'b00, OP_OR=2'b01, OP_XOR=2'b10, OP_NOT=2'b11; state constants ST_IDLE=2'b00, ST_EXEC=2'b01, ST_RESP=2'b10.
- Sub-module logic_unit: purely combinational, with inputs op[1:0], a[WIDTH], b[WIDTH] and output y[WIDTH]. It is reusable by the lab's gate exercises.
- The round-robin pick stays inline as a function/always block in logic_op_arbiter.

Test Plan:
- Reset then single request: req_valid=0001, op=00, A=8'hF0, B=8'h3C, rsp_ready=1 -> req_ready=0001 in cycle 0; rsp_valid in cycle 2 with rsp_id=0, rsp_data=8'h30; ops_done=1.
- Round-robin with all four requesters valid continuously, ops OR/XOR/NOT/AND, A=8'hA5, B=8'h0F -> grants in order 0,1,2,3,0. Results 8'hAF, 8'hAA, 8'h5A, 8'h05.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rsp_id and rsp_data stay constant, req_ready stays 0000, and busy=1. Releasing rsp_ready completes one handshake only.
- Operand change after accept: requester 2 changes A from 8'h11 to 8'hFF in EXEC, op=10, B=8'h01 -> rsp_data=8'h10.
- Reset mid-op: assert rst_n=0 during EXEC -> rsp_valid=0 and busy=0 immediately. After release, the first grant goes to requester 0 when requesters 0 and 3 are both valid.
- Counter saturation: with CNTW=4, 17 operations -> ops_done stops at 4'hF.

Source files
------------

// File: rtl/logic_op_arbiter_pkg.sv
// Shared opcode and state definitions for the
// logic-operation arbiter and its logic unit.
package logic_op_arbiter_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b10;
  localparam logic [1:0] OP_NOT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_EXEC = 2'b01,
    ST_RESP = 2'b10
  } state_t;

endpackage

// File: rtl/logic_unit.sv
// Purely combinational bitwise logic unit.
// NOT uses operand A only; B is ignored.
module logic_unit
  import logic_op_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] y
);

  // Select the bitwise function by opcode
  always_comb begin
    y = '0;
    unique case (op)
      OP_AND: y = a & b;
      OP_OR:  y = a | b;
      OP_XOR: y = a ^ b;
      OP_NOT: y = ~a;
    endcase
  end

endmodule

// File: rtl/logic_op_arbiter.sv
// Round-robin arbiter sharing one logic unit
// between NREQ requesters, tagged response out.
module logic_op_arbiter
  import logic_op_arbiter_pkg::*;
#(
  parameter int NREQ  = 4,
  parameter int WIDTH = 8,
  parameter int IDW   = 2,
  parameter int CNTW  = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [2*NREQ-1:0]     req_op,
  input  logic [WIDTH*NREQ-1:0] req_a,
  input  logic [WIDTH*NREQ-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic [WIDTH-1:0]      rsp_data,
  output logic                  busy,
  output logic [CNTW-1:0]       ops_done
);

  state_t           state;
  state_t           state_nxt;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   grant;
  logic             grant_any;
  logic [IDW-1:0]   cap_id;
  logic [1:0]       cap_op;
  logic [WIDTH-1:0] cap_a;
  logic [WIDTH-1:0] cap_b;
  logic [1:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [WIDTH-1:0] lu_y;
  logic             accept;
  logic             rsp_fire;

  // Nearest valid index after last, wrapping.
  // Returns {found, index}.
  function automatic logic [IDW:0] rr_pick(
    input logic [NREQ-1:0] v,
    input logic [IDW-1:0]  last
  );
    logic [IDW:0] r;
    int           best;
    int           d;
    r    = '0;
    best = NREQ;
    for (int i = 0; i < NREQ; i++) begin
      d = (i + 2*NREQ - int'(last) - 1) % NREQ;
      if (v[i] && d < best) begin
        best = d;
        r    = {1'b1, IDW'(i)};
      end
    end
    return r;
  endfunction

  // Round-robin grant from current requests
  always_comb begin
    {grant_any, grant} = rr_pick(req_valid, last_grant);
  end

  assign accept   = (state == ST_IDLE) && grant_any;
  assign rsp_fire = (state == ST_RESP) && rsp_ready;

  // Ready for the granted requester only, in IDLE
  always_comb begin
    req_ready = '0;
    for (int i = 0; i < NREQ; i++) begin
      req_ready[i] = accept && (grant == IDW'(i));
    end
  end

  // Mux the granted requester's fields
  always_comb begin
    sel_op = '0;
    sel_a  = '0;
    sel_b  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) begin
        sel_op = req_op[2*i +: 2];
        sel_a  = req_a[WIDTH*i +: WIDTH];
        sel_b  = req_b[WIDTH*i +: WIDTH];
      end
    end
  end

  logic_unit #(
    .WIDTH(WIDTH)
  ) u_lu (
    .op(cap_op),
    .a (cap_a),
    .b (cap_b),
    .y (lu_y)
  );

  // Next-state decode; stray code returns to IDLE
  always_comb begin
    state_nxt = ST_IDLE;
    case (state)
      ST_IDLE: begin
        state_nxt = grant_any ? ST_EXEC : ST_IDLE;
      end
      ST_EXEC: begin
        state_nxt = ST_RESP;
      end
      ST_RESP: begin
        state_nxt = rsp_ready ? ST_IDLE : ST_RESP;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture operands on accept, result in EXEC
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_id   <= '0;
      cap_op   <= '0;
      cap_a    <= '0;
      cap_b    <= '0;
      rsp_id   <= '0;
      rsp_data <= '0;
    end else if (accept) begin
      cap_id <= grant;
      cap_op <= sel_op;
      cap_a  <= sel_a;
      cap_b  <= sel_b;
    end else if (state == ST_EXEC) begin
      rsp_id   <= cap_id;
      rsp_data <= lu_y;
    end
  end

  // Fairness pointer and saturating op counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= IDW'(NREQ - 1);
      ops_done   <= '0;
    end else if (rsp_fire) begin
      last_grant <= rsp_id;
      if (ops_done != '1) begin
        ops_done <= ops_done + CNTW'(1);
      end
    end
  end

  assign rsp_valid = (state == ST_RESP);
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Self-checking bench for logic_op_arbiter
// with a behavioural round-robin model.
module tb_logic_op_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = 2;
  localparam int CNTW  = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [7:0]  req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [1:0]  rsp_id;
  logic [7:0]  rsp_data;
  logic        busy;
  logic [3:0]  ops_done;

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;

  int         m_last;
  int         m_done;
  logic [3:0] mask;
  logic [1:0] ops[4];
  logic [7:0] as[4];
  logic [7:0] bs[4];

  logic_op_arbiter #(
    .NREQ (NREQ),
    .WIDTH(WIDTH),
    .IDW  (IDW),
    .CNTW (CNTW)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_op   (req_op),
    .req_a    (req_a),
    .req_b    (req_b),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id   (rsp_id),
    .rsp_data (rsp_data),
    .busy     (busy),
    .ops_done (ops_done)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_checks++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h",
             tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply();
    req_valid = mask;
    for (int i = 0; i < 4; i++) begin
      req_op[2*i +: 2] = ops[i];
      req_a[8*i +: 8]  = as[i];
      req_b[8*i +: 8]  = bs[i];
    end
  endtask

  task automatic scramble();
    mask = 4'($urandom);
    for (int i = 0; i < 4; i++) begin
      ops[i] = 2'($urandom);
      as[i]  = 8'($urandom);
      bs[i]  = 8'($urandom);
    end
    apply();
  endtask

  function automatic int m_pick(input logic [3:0] v);
    int idx;
    for (int k = 1; k <= 4; k++) begin
      idx = (m_last + k) % 4;
      if (v[idx]) return idx;
    end
    return 0;
  endfunction

  function automatic logic [7:0] m_eval(
    input logic [1:0] op,
    input logic [7:0] a,
    input logic [7:0] b
  );
    case (op)
      2'd0:    return a & b;
      2'd1:    return a | b;
      2'd2:    return a ^ b;
      default: return ~a;
    endcase
  endfunction

  task automatic m_reset();
    m_last = 3;
    m_done = 0;
  endtask

  task automatic check_reset();
    check("rst_ready", req_ready, 0);
    check("rst_valid", rsp_valid, 0);
    check("rst_id",    rsp_id,    0);
    check("rst_data",  rsp_data,  0);
    check("rst_busy",  busy,      0);
    check("rst_done",  ops_done,  0);
  endtask

  task automatic pulse_reset();
    rst_n = 1'b0;
    mask  = '0;
    apply();
    #1;
    m_reset();
    check_reset();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic idle_cycle();
    mask = '0;
    apply();
    #1;
    check("idle_ready", req_ready, 0);
    check("idle_busy",  busy,      0);
    tick();
    check("idle_stay",  busy,      0);
    check("idle_rspv",  rsp_valid, 0);
    check("idle_done",  ops_done,  m_done);
  endtask

  // One full operation: accept, EXEC, RESP with
  // optional stall, then handshake.
  task automatic run_op(
    input  int stall,
    output int g
  );
    logic [7:0] exp;
    apply();
    rsp_ready = (stall == 0);
    #1;
    g   = m_pick(mask);
    exp = m_eval(ops[g], as[g], bs[g]);
    check("grant", req_ready, 32'(1 << g));
    check("acc_busy", busy, 0);
    tick();
    scramble();
    #1;
    check("exec_ready", req_ready, 0);
    check("exec_rspv",  rsp_valid, 0);
    check("exec_busy",  busy,      1);
    tick();
    for (int s = 0; s < stall; s++) begin
      scramble();
      #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_id",    rsp_id,    g);
      check("bp_data",  rsp_data,  exp);
      check("bp_ready", req_ready, 0);
      check("bp_busy",  busy,      1);
      tick();
    end
    rsp_ready = 1'b1;
    check("rsp_valid", rsp_valid, 1);
    check("rsp_id",    rsp_id,    g);
    check("rsp_data",  rsp_data,  exp);
    tick();
    m_last = g;
    if (m_done < 15) m_done++;
    check("post_rspv", rsp_valid, 0);
    check("post_busy", busy,      0);
    check("ops_done",  ops_done,  m_done);
  endtask

  initial begin
    int g;
    rst_n     = 1'b1;
    rsp_ready = 1'b0;
    mask      = '0;
    for (int i = 0; i < 4; i++) begin
      ops[i] = '0;
      as[i]  = '0;
      bs[i]  = '0;
    end
    apply();
    #2;
    rst_n = 1'b0;
    #1;
    m_reset();
    check_reset();
    tick();
    tick();
    rst_n = 1'b1;
    idle_cycle();

    // single request, AND
    mask   = 4'b0001;
    ops[0] = 2'b00;
    as[0]  = 8'hF0;
    bs[0]  = 8'h3C;
    run_op(0, g);
    check("single_data", rsp_data, 8'h30);
    check("single_done", ops_done, 1);

    // round robin, all requesters valid
    pulse_reset();
    for (int r = 0; r < 5; r++) begin
      mask   = 4'b1111;
      ops[0] = 2'b01;
      ops[1] = 2'b10;
      ops[2] = 2'b11;
      ops[3] = 2'b00;
      for (int i = 0; i < 4; i++) begin
        as[i] = 8'hA5;
        bs[i] = 8'h0F;
      end
      run_op(0, g);
    end

    // backpressure, then exactly one handshake
    mask   = 4'b0010;
    ops[1] = 2'b10;
    as[1]  = 8'h3C;
    bs[1]  = 8'hFF;
    run_op(5, g);
    idle_cycle();

    // operands change after acceptance
    mask   = 4'b0100;
    ops[2] = 2'b10;
    as[2]  = 8'h11;
    bs[2]  = 8'h01;
    run_op(0, g);
    check("opchg_data", rsp_data, 8'h10);

    // reset in the middle of EXEC
    mask   = 4'b1000;
    ops[3] = 2'b01;
    as[3]  = 8'h0F;
    bs[3]  = 8'hF0;
    apply();
    rsp_ready = 1'b1;
    tick();
    check("pre_rst_busy", busy, 1);
    pulse_reset();
    tick();
    check("mid_rst_rspv", rsp_valid, 0);
    check("mid_rst_done", ops_done,  0);
    mask   = 4'b1001;
    ops[0] = 2'b11;
    as[0]  = 8'h5A;
    run_op(0, g);
    check("mid_rst_id", rsp_id, 0);

    // random traffic, drives counter to saturate
    for (int n = 0; n < 20; n++) begin
      if ($urandom_range(0, 3) == 0) idle_cycle();
      scramble();
      mask = 4'($urandom_range(1, 15));
      run_op(int'($urandom_range(0, 2)), g);
    end
    check("sat_done", ops_done, 4'hF);

    $display("%0d/%0d checks passed",
             n_pass, n_checks);
    $finish;
  end

endmodule
